// File: rtl/uart_rx_core.sv
// 8N1 UART receiver core: armed by a one-cycle start pulse, captures one byte,
// reports it through sticky rx_done / frame_err levels.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       start,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       rx_done,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_rxs;
    logic            r_rxs_d;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic [7:0]      r_data;
    logic [7:0]      w_data_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_ferr;
    logic            w_ferr_nxt;
    logic            w_fall;

    // A line already low when armed never produces this pulse.
    assign w_fall = r_rxs_d & ~r_rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_rxs_d <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sync1 <= uart_rx;
            r_rxs   <= r_sync1;
            r_rxs_d <= r_rxs;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_done_nxt  = r_done;
        w_ferr_nxt  = r_ferr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ARMED;
                    w_done_nxt  = 1'b0;
                    w_ferr_nxt  = 1'b0;
                end
            end
            S_ARMED: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                // Mid-start-bit check rejects short glitches.
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt = '0;
                    if (!r_rxs) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_ARMED;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rxs, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (r_rxs) begin
                        w_data_nxt = r_shift;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign data_out  = r_data;
    assign ready     = (r_state == S_IDLE);
    assign rx_done   = r_done;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized bench for uart_rx_core: drives 8N1 frames and compares the
// outputs against a byte-level model of the receiver's flag rules.
module tb_uart_rx_core;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       start;
    logic [7:0] data_out;
    logic       ready;
    logic       rx_done;
    logic       frame_err;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] exp_data;
    logic       exp_done;
    logic       exp_ferr;
    int         done_at;

    always #5 clk = ~clk;

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .start    (start),
        .data_out (data_out),
        .ready    (ready),
        .rx_done  (rx_done),
        .frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            uart_rx = 1'b1;
            start   = 1'b0;
            rst     = 1'b0;
        end
    endtask

    task automatic arm();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_done = 1'b0;
        exp_ferr = 1'b0;
        chk("arm_ready", ready, 0);
        chk("arm_done", rx_done, exp_done);
        chk("arm_ferr", frame_err, exp_ferr);
        chk("arm_data", data_out, exp_data);
    endtask

    // Model: a good stop bit publishes the byte; a bad one only flags.
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            exp_data = b;
            exp_done = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_data"}, data_out, exp_data);
        chk({tag, "_done"}, rx_done, exp_done);
        chk({tag, "_ferr"}, frame_err, exp_ferr);
        chk({tag, "_ready"}, ready, 1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int start_bit, input int rst_bit);
        logic [9:0] bits;
        bits    = {stop, b, 1'b0};
        done_at = -1;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (done_at < 0 && rx_done === 1'b1) done_at = i * CPB + c;
                if (rst_bit >= 0 && i == rst_bit + 1 && c == 9) begin
                    exp_data = 8'h00;
                    exp_done = 1'b0;
                    exp_ferr = 1'b0;
                    chk("rst_ready", ready, 1);
                    chk("rst_done", rx_done, 0);
                    chk("rst_ferr", frame_err, 0);
                    chk("rst_data", data_out, 8'h00);
                end
                uart_rx = bits[i];
                start   = (start_bit >= 0 && i == start_bit + 1 && c == 8);
                rst     = (rst_bit >= 0 && i == rst_bit + 1 && c == 8);
            end
        end
        @(negedge clk);
        uart_rx = 1'b1;
        start   = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic       s;
        uart_rx  = 1'b1;
        start    = 1'b0;
        rst      = 1'b1;
        exp_data = 8'h00;
        exp_done = 1'b0;
        exp_ferr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", ready, 1);
        chk("reset_done", rx_done, 0);
        chk("reset_ferr", frame_err, 0);
        chk("reset_data", data_out, 8'h00);
        idle(5);

        arm();
        send_frame(8'hA5, 1'b1, -1, -1);
        model_frame(8'hA5, 1'b1);
        check_out("good_a5");
        chk("latency", (done_at >= 154 && done_at <= 156), 1);

        arm();
        send_frame(8'h3C, 1'b0, -1, -1);
        model_frame(8'h3C, 1'b0);
        check_out("ferr_3c");

        arm();
        repeat (3) begin
            @(negedge clk);
            uart_rx = 1'b0;
        end
        idle(20);
        chk("glitch_ready", ready, 0);
        chk("glitch_done", rx_done, exp_done);
        chk("glitch_ferr", frame_err, exp_ferr);
        send_frame(8'h81, 1'b1, -1, -1);
        model_frame(8'h81, 1'b1);
        check_out("after_glitch_81");

        arm();
        send_frame(8'h55, 1'b1, 3, -1);
        model_frame(8'h55, 1'b1);
        check_out("busy_55");

        arm();
        idle(300);
        chk("rearm_wait_ready", ready, 0);
        chk("rearm_wait_data", data_out, exp_data);
        b = 8'($urandom);
        send_frame(b, 1'b1, -1, -1);
        model_frame(b, 1'b1);
        check_out("rearm_rand");

        arm();
        send_frame(8'h6B, 1'b1, -1, 4);
        check_out("rst_mid");
        arm();
        send_frame(8'hFF, 1'b1, -1, -1);
        model_frame(8'hFF, 1'b1);
        check_out("post_rst_ff");

        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            arm();
            idle($urandom_range(0, 40));
            send_frame(b, s, -1, -1);
            model_frame(b, s);
            check_out("rand");
            idle($urandom_range(0, 10));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit; legal range is >= 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port uart_rx, input, 1 bit: asynchronous serial line; idle high; 8N1 format, LSB first.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle arm pulse from the UART RX CSR block (U_CTRL.START).
REQ-006 The block SHALL have port data_out, output, 8 bits: last correctly framed byte; drives U_DATA.DATA.
REQ-007 The block SHALL have port ready, output, 1 bit: high when the receiver is idle and can accept start; drives U_STAT.READY.
REQ-008 The block SHALL have port rx_done, output, 1 bit: sticky level, high after a good byte is received; drives U_STAT.RX_DONE.
REQ-009 The block SHALL have port frame_err, output, 1 bit: sticky level, high after a byte with a low stop bit.

Function
REQ-010 uart_rx SHALL pass through a 2-flop synchronizer (reset value 1) and an edge-detect flop; only the synchronized value (rxs) is used internally.
REQ-011 The FSM SHALL have five states, IDLE, ARMED, START_BIT, DATA, STOP, and SHALL be encoded in 3 bits.
REQ-012 ready SHALL be 1 in IDLE and 0 in every other state.
REQ-013 IDLE with start=1 SHALL move to ARMED on the next edge, clearing rx_done and frame_err on that same edge; data_out is held.
REQ-014 start SHALL be ignored in any state other than IDLE.
REQ-015 ARMED SHALL wait indefinitely for an rxs 1->0 transition; a line that is already low on arming SHALL NOT count as an edge.
REQ-016 On the falling edge, the FSM SHALL enter START_BIT with the bit counter set to 0.
REQ-017 START_BIT SHALL count to CLKS_PER_BIT/2-1 (integer division), then sample rxs.
REQ-018 In START_BIT, a sample of 0 SHALL move the FSM to DATA with the counter and bit index cleared.
REQ-019 In START_BIT, a sample of 1 (glitch) SHALL return the FSM to ARMED with no flag change.
REQ-020 DATA SHALL sample rxs each time the counter reaches CLKS_PER_BIT-1, then clear the counter.
REQ-021 Each DATA sample SHALL be shifted into an 8-bit shift register MSB-side, so bit 0 arrives first.
REQ-022 After the 8th DATA sample (bit index 7), the FSM SHALL move to STOP.
REQ-023 STOP SHALL sample rxs when the counter reaches CLKS_PER_BIT-1.
REQ-024 A STOP sample of 1 SHALL, on one edge: load data_out from the shift register, set rx_done=1, and return to IDLE.
REQ-025 A STOP sample of 0 SHALL set frame_err=1, leave data_out and rx_done unchanged, and return to IDLE.
REQ-026 Latency from the rxs falling edge to rx_done high SHALL be exactly CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, +/-1.
REQ-027 The counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never wrap within a bit period.
REQ-028 rx_done and frame_err SHALL hold until the next accepted start or until reset.
REQ-029 The shift register SHALL be internal only; data_out SHALL change only on a good stop bit.

Reset
REQ-030 rst=1 SHALL force IDLE, ready=1, rx_done=0, frame_err=0, data_out=8'h00, counter=0, shift register=0, and synchronizer flops=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no partial data_out update; after release the block SHALL be in IDLE with ready=1.

Verification (CLKS_PER_BIT=16)
REQ-032 Good byte: start pulse, then frame 0xA5 with a good stop bit -> ready drops to 0 the cycle after start; data_out=0xA5, rx_done=1, ready=1 about 152 cycles after the rxs edge.
REQ-033 Framing error: frame 0x3C with stop bit driven low -> frame_err=1, rx_done=0, data_out keeps its prior value, FSM in IDLE.
REQ-034 False start: armed, uart_rx low for 3 cycles then high -> FSM returns to ARMED, ready=0, no flag change; a following 0x81 frame is received correctly.
REQ-035 Start while busy: start pulsed mid-DATA during a 0x55 frame -> ignored; data_out=0x55, rx_done=1.
REQ-036 Re-arm: start while rx_done=1 -> rx_done=0 the next cycle, data_out unchanged; line held idle -> ready stays 0 indefinitely.
REQ-037 Reset mid-frame: rst pulsed during bit 4 -> the reset values of REQ-030 are restored; a subsequent armed 0xFF frame is received correctly.
